// File: rtl/vx_gbar_unit.sv
// Global barrier unit: tracks per-barrier core arrival masks and broadcasts
// a one-cycle release when the last participating core arrives.
module vx_gbar_unit #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8,
    localparam int NC_W = (NUM_CORES    > 1) ? $clog2(NUM_CORES)    : 1,
    localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [NB_W-1:0] req_id,
    input  logic [NC_W-1:0] req_size_m1,
    input  logic [NC_W-1:0] req_core_id,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [NB_W-1:0] rsp_id,
    output logic            busy,
    output logic            dup_err,
    output logic [31:0]     release_count
);
    localparam int STAGES = 1;

    typedef struct packed {
        logic [NB_W-1:0] id;
        logic [NC_W-1:0] size_m1;
        logic [NC_W-1:0] core_id;
    } req_t;

    req_t req;
    assign req = '{id: req_id, size_m1: req_size_m1, core_id: req_core_id};

    logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] arr_mask, mask_nxt;
    logic [NUM_CORES-1:0] cur_mask, core_oh;
    logic [NC_W:0]        cnt;
    logic                 accept, in_range, dup, rel, set_arr, bad;
    logic [STAGES:0]      vld_pipe;

    assign req_ready = ~reset;
    assign accept    = req_valid & req_ready;
    assign in_range  = (int'(req.core_id) < NUM_CORES) && (int'(req.id) < NUM_BARRIERS);

    // Select the addressed mask by compare rather than indexing so an
    // out-of-range ID never reads past the array.
    always_comb begin
        cur_mask = '0;
        core_oh  = '0;
        cnt      = '0;
        for (int b = 0; b < NUM_BARRIERS; b++)
            if (req.id == NB_W'(b)) cur_mask = arr_mask[b];
        for (int c = 0; c < NUM_CORES; c++) begin
            core_oh[c] = (req.core_id == NC_W'(c));
            cnt        = cnt + {{NC_W{1'b0}}, cur_mask[c]};
        end
    end

    assign dup     = |(cur_mask & core_oh);
    assign rel     = accept & in_range & ~dup & (cnt == {1'b0, req.size_m1});
    assign set_arr = accept & in_range & ~dup & ~rel;
    assign bad     = accept & (~in_range | dup);

    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_bar
        logic hit;
        assign hit         = (req.id == NB_W'(b));
        assign mask_nxt[b] = (rel & hit) ? '0
                           : (arr_mask[b] | ((set_arr & hit) ? core_oh : '0));
    end

    assign vld_pipe[0] = rel;
    assign rsp_valid   = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            arr_mask             <= '0;
            vld_pipe[STAGES:1]   <= '0;
            rsp_id               <= '0;
            busy                 <= 1'b0;
            dup_err              <= 1'b0;
            release_count        <= '0;
        end else begin
            arr_mask             <= mask_nxt;
            vld_pipe[STAGES:1]   <= vld_pipe[STAGES-1:0];
            busy                 <= |mask_nxt;
            dup_err              <= bad;
            // rsp_id only moves on a release so it holds between broadcasts
            if (rel) begin
                rsp_id        <= req.id;
                release_count <= release_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_vx_gbar_unit.sv
// Scoreboard bench for vx_gbar_unit: driver queues expected releases and
// duplicate pulses, a negedge monitor pops and compares them.
module tb_vx_gbar_unit;
    localparam int NC = 4;
    localparam int NB = 6;
    localparam int NC_W = 2;
    localparam int NB_W = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic [NB_W-1:0] req_id;
    logic [NC_W-1:0] req_size_m1;
    logic [NC_W-1:0] req_core_id;
    logic            req_ready;
    logic            rsp_valid;
    logic [NB_W-1:0] rsp_id;
    logic            busy;
    logic            dup_err;
    logic [31:0]     release_count;

    vx_gbar_unit #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id),
        .req_size_m1(req_size_m1), .req_core_id(req_core_id), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .busy(busy), .dup_err(dup_err),
        .release_count(release_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    exp_t rq[$];
    int   dq[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rsp/dup pulse must match the head of its queue at the
    // predicted cycle; an overdue head is a missed response.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid) begin
            if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_id), 32'hdead);
            else begin
                e = rq.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
            e = rq.pop_front();
            chk("rsp_missing", 32'(rsp_valid), 32'd1);
        end
        if (dup_err) begin
            if (dq.size() == 0) chk("dup_unexpected", 32'(dup_err), 32'd0);
            else chk("dup_cycle", 32'(cyc), 32'(dq.pop_front()));
        end else if (dq.size() > 0 && dq[0] < cyc) begin
            void'(dq.pop_front());
            chk("dup_missing", 32'(dup_err), 32'd1);
        end
    end

    task automatic arrive(input int id, input int sz, input int core, input bit rel, input bit dp);
        exp_t e;
        req_valid   = 1'b1;
        req_id      = NB_W'(id);
        req_size_m1 = NC_W'(sz);
        req_core_id = NC_W'(core);
        if (rel) begin
            e.id  = id;
            e.cyc = cyc + 1;
            rq.push_back(e);
        end
        if (dp) dq.push_back(cyc + 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_id = '0;
        req_size_m1 = '0;
        req_core_id = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dup", 32'(dup_err), 32'd0);
        chk("rst_count", release_count, 32'd0);
        reset = 1'b0;
        #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

        // four cores on ID 2, first accept right after reset
        arrive(2, 3, 0, 0, 0);
        chk("busy_first_arrival", 32'(busy), 32'd1);
        arrive(2, 3, 1, 0, 0);
        arrive(2, 3, 2, 0, 0);
        arrive(2, 3, 3, 1, 0);
        chk("busy_after_release", 32'(busy), 32'd0);
        chk("count_1", release_count, 32'd1);
        idle(1);
        chk("rsp_id_hold", 32'(rsp_id), 32'd2);

        // duplicate arrival then completion
        arrive(5, 1, 1, 0, 0);
        arrive(5, 1, 1, 0, 1);
        arrive(5, 1, 0, 1, 0);
        idle(1);
        chk("count_2", release_count, 32'd2);

        // single-core barrier
        arrive(0, 0, 3, 1, 0);
        chk("busy_size0", 32'(busy), 32'd0);

        // interleaved IDs completing back to back
        arrive(1, 1, 0, 0, 0);
        arrive(3, 1, 0, 0, 0);
        arrive(1, 1, 2, 1, 0);
        arrive(3, 1, 1, 1, 0);

        // release followed immediately by a fresh epoch on the same ID
        arrive(4, 1, 0, 0, 0);
        arrive(4, 1, 1, 1, 0);
        arrive(4, 1, 1, 0, 0);
        arrive(4, 1, 0, 1, 0);
        arrive(5, 0, 2, 1, 0);
        arrive(5, 0, 2, 1, 0);
        idle(1);
        chk("count_9", release_count, 32'd9);

        // out-of-range IDs are dropped with an error pulse
        arrive(6, 0, 0, 0, 1);
        arrive(7, 1, 3, 0, 1);
        chk("busy_oor", 32'(busy), 32'd0);
        arrive(3, 1, 3, 0, 0);
        arrive(3, 1, 2, 1, 0);
        idle(1);
        chk("count_10", release_count, 32'd10);

        // partial arrivals discarded by reset
        arrive(4, 3, 0, 0, 0);
        arrive(4, 3, 1, 0, 0);
        chk("busy_partial", 32'(busy), 32'd1);
        reset = 1'b1;
        idle(2);
        chk("busy_reset_mid", 32'(busy), 32'd0);
        chk("count_reset_mid", release_count, 32'd0);
        reset = 1'b0;
        arrive(4, 3, 0, 0, 0);
        arrive(4, 3, 1, 0, 0);
        arrive(4, 3, 2, 0, 0);
        arrive(4, 3, 3, 1, 0);
        idle(1);
        chk("count_post_reset", release_count, 32'd1);

        // counter wrap
        force dut.release_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.release_count;
        chk("count_forced", release_count, 32'hFFFF_FFFF);
        arrive(0, 0, 1, 1, 0);
        chk("count_wrap", release_count, 32'd0);

        idle(3);
        chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
        chk("dup_queue_drained", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vx_gbar_unit.md
VX_GBAR_UNIT -- requirements
Module: VX_gbar_unit

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: cores sharing the global barrier bus (>=1).
REQ-002 SHALL have parameter NUM_BARRIERS, default 8: barrier IDs tracked.
REQ-003 SHALL derive NC_W = max(1, ceil(log2(NUM_CORES))) and NB_W = max(1, ceil(log2(NUM_BARRIERS))).
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1: core barrier-arrival request.
REQ-007 SHALL have port req_id, input, NB_W: barrier ID.
REQ-008 SHALL have port req_size_m1, input, NC_W: participating cores minus one.
REQ-009 SHALL have port req_core_id, input, NC_W: requesting core.
REQ-010 SHALL have port req_ready, output, 1: request accepted this cycle.
REQ-011 SHALL have port rsp_valid, output, 1: barrier release broadcast, no backpressure.
REQ-012 SHALL have port rsp_id, output, NB_W: released barrier ID.
REQ-013 SHALL have port busy, output, 1: any barrier has arrived cores.
REQ-014 SHALL have port dup_err, output, 1: duplicate-arrival pulse.
REQ-015 SHALL have port release_count, output, 32: total releases issued.

Function
REQ-016 SHALL hold per-barrier arrival masks arr_mask[NUM_BARRIERS][NUM_CORES].
REQ-017 SHALL drive req_ready=1 every cycle except while reset is high.
REQ-018 SHALL define accept = req_valid & req_ready; at most one acceptance per cycle.
REQ-019 SHALL compute cnt = popcount(arr_mask[req_id]) as a NC_W+1-bit value, combinationally, in the accept cycle.
REQ-020 SHALL define dup = arr_mask[req_id][req_core_id] on accept.
REQ-021 On accept with dup=1: SHALL leave all masks unchanged, SHALL pulse dup_err for one cycle in the next cycle, SHALL NOT release.
REQ-022 On accept with dup=0 and cnt == req_size_m1 (zero-extended): SHALL clear arr_mask[req_id] to 0 and release that barrier.
REQ-023 On accept with dup=0 and cnt != req_size_m1: SHALL set arr_mask[req_id][req_core_id]=1.
REQ-024 Release SHALL register rsp_valid=1 and rsp_id=req_id in the cycle after accept (latency 1), rsp_valid high exactly one cycle per release.
REQ-025 rsp_id SHALL hold its last value when rsp_valid=0.
REQ-026 req_size_m1 = 0 SHALL release on the first accept, with no mask bit ever set.
REQ-027 Back-to-back accepts on the same ID SHALL see mask updates from the prior cycle; a release in cycle N and a new arrival in cycle N+1 start a fresh epoch.
REQ-028 Consecutive releases (different or same ID) SHALL produce rsp_valid on consecutive cycles without gaps.
REQ-029 req_core_id >= NUM_CORES or req_id >= NUM_BARRIERS SHALL be ignored (no state change), with dup_err pulsed.
REQ-030 release_count SHALL increment by 1 per release, wrapping modulo 2^32.
REQ-031 busy SHALL be the registered OR of all arr_mask bits, reflecting state after the current cycle's update.

Reset
REQ-032 On reset: arr_mask all 0, rsp_valid=0, rsp_id=0, dup_err=0, busy=0, release_count=0, req_ready=0.
REQ-033 Reset mid-epoch SHALL discard partial arrivals; a release pending for the following cycle SHALL NOT be emitted.
REQ-034 The first accept SHALL occur in the first cycle after reset deasserts.

Verification
REQ-035 NUM_CORES=4: cores 0,1,2,3 arrive on ID 2 with size_m1=3 on cycles 1-4 -> rsp_valid=1, rsp_id=2 on cycle 5 only; busy=0 after; release_count=1.
REQ-036 Core 1 arrives on ID 5 twice (size_m1=1) -> second arrival gives dup_err pulse, no rsp; then core 0 arrives -> rsp_id=5 next cycle.
REQ-037 size_m1=0 from core 3 on ID 0 -> rsp_valid next cycle, busy stays 0.
REQ-038 Interleaved IDs 1 and 3 (size_m1=1) completing on consecutive cycles -> rsp_id=1 then rsp_id=3 on back-to-back cycles.
REQ-039 Two of four cores arrive on ID 4, reset pulsed, then all four arrive -> exactly one release, after the fourth post-reset arrival.
REQ-040 Preload release_count to 0xFFFFFFFF by forcing, one release -> count reads 0.
